rbf_kernel_arbiter: RTL and testbench

Shares one non-pipelined pairwise_dist_sq_rbf kernel instance (ap_ctrl_hs) between NUM_REQ requesters inside myproject. Round-robin grant, drives the kernel's ap_start, and returns per-requester ready/done pulses. grant_id steers the external operand/result muxes. Adds watchdog timeout and per-transaction cycle statistics for cosim debug.

---
 rtl/rbf_kernel_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rbf_kernel_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rbf_kernel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rbf_kernel_arbiter
// Description : Round-robin arbiter sharing one ap_ctrl_hs pairwise_dist_sq_rbf
//               kernel between NUM_REQ requesters. Drives ap_start, returns
//               per-requester ready/done pulses, steers operand muxes through
//               grant_id, and keeps a watchdog plus per-transaction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module rbf_kernel_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_REQ-1:0] req_start,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] req_done,
  output logic               krn_ap_start,
  input  logic               krn_ap_ready,
  input  logic               krn_ap_done,
  input  logic               krn_ap_idle,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   busy_cycles,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int WD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_idx;
  logic                win_found;

  logic [WD_W-1:0]     wd_cnt;
  logic [CNT_W-1:0]    cyc_cnt;

  logic                active;
  logic                grant_fire;
  logic                ready_fire;
  logic                done_fire;
  logic                wd_fire;
  logic [NUM_REQ-1:0]  grant_oh;

  // Round-robin search: first requesting bit strictly after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_start[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Transaction events; a done in START only counts alongside the ready.
  always_comb begin
    active     = (state == ST_START) || (state == ST_RUN);
    grant_fire = (state == ST_IDLE) && win_found && krn_ap_idle;
    ready_fire = (state == ST_START) && krn_ap_ready;
    done_fire  = ((state == ST_RUN) && krn_ap_done) || (ready_fire && krn_ap_done);
    wd_fire    = (TIMEOUT_CYCLES != 0) && active && !done_fire &&
                 (wd_cnt == WD_W'(TIMEOUT_CYCLES));
  end

  // Handshake outputs: one-hot pulses steered to the current owner only.
  always_comb begin
    grant_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    req_ready    = ready_fire ? grant_oh : '0;
    req_done     = done_fire  ? grant_oh : '0;
    krn_ap_start = (state == ST_START);
    grant_valid  = (state != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; the watchdog overrides normal progress.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_fire) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (wd_fire) begin
          state_nxt = ST_IDLE;
        end else if (ready_fire) begin
          state_nxt = done_fire ? ST_IDLE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (wd_fire || done_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant ownership and round-robin pointer update on each new grant.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (grant_fire) begin
      grant_id <= win_id;
      rr_ptr   <= win_id;
    end
  end

  // Per-transaction cycle and watchdog counters; the grant cycle preloads 1 so
  // the first ap_start cycle is counted inclusively.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc_cnt <= '0;
      wd_cnt  <= '0;
    end else if (grant_fire) begin
      cyc_cnt <= CNT_W'(1);
      wd_cnt  <= WD_W'(1);
    end else if (active) begin
      cyc_cnt <= (cyc_cnt == {CNT_W{1'b1}}) ? cyc_cnt : cyc_cnt + 1'b1;
      wd_cnt  <= (wd_cnt == {WD_W{1'b1}}) ? wd_cnt : wd_cnt + 1'b1;
    end
  end

  // Completion statistics: latch transaction length and count completions.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      busy_cycles <= '0;
      txn_count   <= '0;
    end else if (done_fire) begin
      busy_cycles <= cyc_cnt;
      txn_count   <= txn_count + 1'b1;
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timeout_err <= 1'b0;
    end else if (wd_fire) begin
      timeout_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rbf_kernel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbf_kernel_arbiter
// Description : Directed self-checking bench for rbf_kernel_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbf_kernel_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_start;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        krn_ap_start;
  logic        krn_ap_ready;
  logic        krn_ap_done;
  logic        krn_ap_idle;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [31:0] busy_cycles;
  logic [31:0] txn_count;

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;

  rbf_kernel_arbiter #(
    .NUM_REQ(4),
    .ID_W(2),
    .TIMEOUT_CYCLES(16),
    .CNT_W(32)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .req_start(req_start),
    .req_ready(req_ready),
    .req_done(req_done),
    .krn_ap_start(krn_ap_start),
    .krn_ap_ready(krn_ap_ready),
    .krn_ap_done(krn_ap_done),
    .krn_ap_idle(krn_ap_idle),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout_err(timeout_err),
    .busy_cycles(busy_cycles),
    .txn_count(txn_count)
  );

  always #5 ap_clk = ~ap_clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction; entered and left at negedge+1 with the DUT in IDLE.
  task automatic do_txn(input logic [3:0] req, input int rdy_at, input int done_at,
                        input logic [1:0] exp_id, input int exp_busy, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    req_start = req;
    #1;
    chk("idle_no_start", krn_ap_start, 1'b0);
    @(negedge ap_clk);
    #1;
    chk("grant_id", grant_id, exp_id);
    chk("grant_valid", grant_valid, 1'b1);
    for (int c = 1; c <= done_at; c++) begin
      if (c > 1) @(negedge ap_clk);
      krn_ap_ready = (c == rdy_at);
      krn_ap_done  = (c == done_at);
      #1;
      chk("ap_start", krn_ap_start, (c <= rdy_at));
      chk("req_ready", req_ready, (c == rdy_at) ? oh : 4'b0000);
      chk("req_done", req_done, (c == done_at) ? oh : 4'b0000);
      if (drop && c == rdy_at) req_start = req_start & ~oh;
    end
    @(negedge ap_clk);
    krn_ap_ready = 1'b0;
    krn_ap_done  = 1'b0;
    exp_txn++;
    #1;
    chk("post_grant_valid", grant_valid, 1'b0);
    chk("busy_cycles", busy_cycles, exp_busy);
    chk("txn_count", txn_count, exp_txn);
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    req_start    = 4'b0000;
    krn_ap_ready = 1'b0;
    krn_ap_done  = 1'b0;
    krn_ap_idle  = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("rst_ap_start", krn_ap_start, 1'b0);
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_busy", busy_cycles, 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #1;

    // Contention: all held, order 0,1,2,3,0.
    do_txn(4'b1111, 1, 3, 2'd0, 3, 1'b0);
    do_txn(4'b1111, 2, 2, 2'd1, 2, 1'b0);
    do_txn(4'b1111, 1, 4, 2'd2, 4, 1'b0);
    do_txn(4'b1111, 1, 3, 2'd3, 3, 1'b0);
    do_txn(4'b1111, 1, 3, 2'd0, 3, 1'b0);
    req_start = 4'b0000;

    // Single request: ready at 3, done at 10.
    @(negedge ap_clk);
    #1;
    do_txn(4'b0100, 3, 10, 2'd2, 10, 1'b1);

    // Rotation after grant 2: wrap past 3 to 0, then 2.
    do_txn(4'b0101, 1, 2, 2'd0, 2, 1'b1);
    do_txn(req_start, 1, 2, 2'd2, 2, 1'b1);

    // Ready and done in the first start cycle.
    do_txn(4'b0010, 1, 1, 2'd1, 1, 1'b1);

    // Timeout: ready given, done withheld for 16 cycles.
    req_start = 4'b1000;
    @(negedge ap_clk);
    #1;
    chk("to_grant_id", grant_id, 2'd3);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge ap_clk);
      krn_ap_ready = (c == 2);
      #1;
      chk("to_req_done", req_done, 4'b0000);
      if (c == 2) req_start = 4'b0000;
    end
    @(negedge ap_clk);
    krn_ap_ready = 1'b0;
    #1;
    chk("to_err", timeout_err, 1'b1);
    chk("to_grant_valid", grant_valid, 1'b0);
    chk("to_ap_start", krn_ap_start, 1'b0);
    chk("to_txn", txn_count, exp_txn);
    chk("to_busy", busy_cycles, 32'd1);
    do_txn(4'b0001, 2, 4, 2'd0, 4, 1'b1);
    chk("to_sticky", timeout_err, 1'b1);

    // Idle gating: no start while the kernel reports busy.
    krn_ap_idle = 1'b0;
    req_start   = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      #1;
      chk("gate_ap_start", krn_ap_start, 1'b0);
    end
    krn_ap_idle = 1'b1;
    @(negedge ap_clk);
    #1;
    chk("gate_released", krn_ap_start, 1'b1);
    chk("gate_id", grant_id, 2'd0);
    krn_ap_ready = 1'b1;
    req_start    = 4'b0000;
    @(negedge ap_clk);
    krn_ap_ready = 1'b0;
    @(negedge ap_clk);
    #1;
    chk("run_grant_valid", grant_valid, 1'b1);

    // Reset during RUN with done raised: everything clears, no done pulse.
    ap_rst_n    = 1'b0;
    krn_ap_done = 1'b1;
    #1;
    chk("mid_rst_valid", grant_valid, 1'b0);
    chk("mid_rst_done", req_done, 4'b0000);
    chk("mid_rst_timeout", timeout_err, 1'b0);
    chk("mid_rst_txn", txn_count, 32'd0);
    chk("mid_rst_busy", busy_cycles, 32'd0);
    @(negedge ap_clk);
    krn_ap_done = 1'b0;
    ap_rst_n    = 1'b1;
    exp_txn     = 0;
    @(negedge ap_clk);
    #1;
    do_txn(4'b0011, 1, 2, 2'd0, 2, 1'b1);
    req_start = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
